// File: rtl/axi_rd_responder_if.sv
// axi_rd_responder_if
//   Cache-side read channel bundle for axi_rd_responder.
//   master : requester (drives request, address, type, rready)
//   slave  : responder (drives arready, rvalid, rdata, rlast)
interface axi_rd_responder_if;
   logic        axi_rreq;
   logic [1:0]  axi_rtype;
   logic [31:0] axi_raddr;
   logic        axi_rready;
   logic        axi_arready;
   logic        axi_rvalid;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rlast;

   modport master (
      output axi_rreq, axi_rtype, axi_raddr, axi_rready,
      input  axi_arready, axi_rvalid, axi_rdata, axi_rlast
   );

   modport slave (
      input  axi_rreq, axi_rtype, axi_raddr, axi_rready,
      output axi_arready, axi_rvalid, axi_rdata, axi_rlast
   );
endinterface

// File: rtl/axi_rd_responder.sv
// axi_rd_responder
//   Answers single-beat and line-burst read requests from a synchronous RAM.
//   Ports:
//     clk        - rising-edge clock
//     rst        - asynchronous active-high reset
//     axi        - read channel (slave modport): rreq/rtype/raddr/rready in,
//                  arready/rvalid/rdata/rlast out
//     ram_en     - RAM read strobe
//     ram_addr   - RAM byte address (word aligned)
//     ram_rdata  - RAM data, valid the cycle after ram_en
module axi_rd_responder #(
   parameter int unsigned BURST_LEN  = 8,
   parameter logic [1:0]  LINE_RTYPE = 2'b11
) (
   input  logic                clk,
   input  logic                rst,
   axi_rd_responder_if.slave   axi,
   output logic                ram_en,
   output logic [31:0]         ram_addr,
   input  logic [31:0]         ram_rdata
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);

   logic [0:0]  state;
   logic [31:0] base;
   logic [3:0]  count;
   logic [3:0]  issue_cnt;
   logic [3:0]  beat_cnt;
   logic        pend;
   logic [31:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  occ;

   logic accept, rvalid, pop, fifo_pop, push, last_hs, room;
   logic unused_raddr_lsb;

   assign unused_raddr_lsb = ^axi.axi_raddr[1:0];

   assign axi.axi_arready = (state == IDLE) && !rst;
   assign accept          = axi.axi_rreq && axi.axi_arready;

   // The returning RAM word is visible straight away (write-through FIFO),
   // which gives the first beat one cycle after ram_en. If it is not taken
   // in that cycle it is captured and re-presented from the FIFO head.
   assign rvalid   = (occ != 2'd0) || pend;
   assign pop      = rvalid && axi.axi_rready;
   assign fifo_pop = pop && (occ != 2'd0);
   assign push     = pend && !(pop && (occ == 2'd0));
   assign last_hs  = pop && (beat_cnt == count - 4'd1);

   assign axi.axi_rvalid = rvalid;
   assign axi.axi_rdata  = (occ != 2'd0) ? mem[rd_ptr] :
                           (pend ? ram_rdata : '0);
   assign axi.axi_rlast  = (rvalid && (beat_cnt == count - 4'd1)) ? 2'b01 : 2'b00;

   // In-flight read plus stored beats may never exceed the two FIFO slots.
   assign room     = ({2'b00, pend} + {1'b0, occ}) < 3'd2;
   assign ram_en   = (state == RUN) && room && (issue_cnt < count);
   assign ram_addr = base + {26'b0, issue_cnt, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         count     <= '0;
         issue_cnt <= '0;
         beat_cnt  <= '0;
         pend      <= 1'b0;
         mem[0]    <= '0;
         mem[1]    <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         occ       <= '0;
      end else begin
         pend <= ram_en;

         if (push) begin
            mem[wr_ptr] <= ram_rdata;
            wr_ptr      <= ~wr_ptr;
         end
         if (fifo_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, fifo_pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase

         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RUN;
                  issue_cnt <= '0;
                  beat_cnt  <= '0;
                  if (axi.axi_rtype == LINE_RTYPE) begin
                     base  <= {axi.axi_raddr[31:5], 5'b0};
                     count <= BURST_CNT;
                  end else begin
                     base  <= {axi.axi_raddr[31:2], 2'b00};
                     count <= 4'd1;
                  end
               end
            end
            default: begin
               if (ram_en) issue_cnt <= issue_cnt + 4'd1;
               if (pop)    beat_cnt  <= beat_cnt + 4'd1;
               if (last_hs) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/axi_rd_responder.md
AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, which is the beat count of a line read (power of two, 2..8).
REQ-002 SHALL have parameter LINE_RTYPE, default 2'b11, which is the rtype value that selects a line burst.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port axi_rreq, input, 1 bit: read request from the cache side.
REQ-006 SHALL have port axi_rtype, input, 2 bits: LINE_RTYPE selects a burst; any other value selects a single beat.
REQ-007 SHALL have port axi_raddr, input, 32 bits: physical byte address of the request.
REQ-008 SHALL have port axi_rready, input, 1 bit: the requester accepts the current beat.
REQ-009 SHALL have port axi_arready, output, 1 bit: the request can be accepted this cycle.
REQ-010 SHALL have port axi_rvalid, output, 1 bit: axi_rdata holds a valid beat.
REQ-011 SHALL have port axi_rdata, output, 32 bits: beat data.
REQ-012 SHALL have port axi_rlast, output, 2 bits: 2'b01 on the final beat of a transaction, 2'b00 otherwise.
REQ-013 SHALL have port ram_en, output, 1 bit: read strobe to a synchronous RAM.
REQ-014 SHALL have port ram_addr, output, 32 bits: byte address to the RAM, with [1:0]=2'b00.
REQ-015 SHALL have port ram_rdata, input, 32 bits: RAM data, valid exactly 1 cycle after ram_en.

Function
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 SHALL drive axi_arready=1 only in IDLE.
REQ-018 SHALL treat axi_rreq&&axi_arready as request acceptance, which moves the FSM IDLE->RUN.
REQ-019 SHALL latch on acceptance: base address {raddr[31:5],5'b0} for a burst, or {raddr[31:2],2'b00} for a single beat; beat count BURST_LEN for a burst, or 1 for a single beat.
REQ-020 SHALL generate incrementing beat addresses base+4*i for i=0..count-1, with no wrap; a burst is line-aligned regardless of raddr[4:2].
REQ-021 SHALL return data in a 2-entry FIFO; ram_en is asserted in RUN only when issued-not-yet-returned reads plus FIFO occupancy is less than 2 and beats remain to issue.
REQ-022 SHALL write ram_rdata into the FIFO in the cycle after each ram_en.
REQ-023 SHALL drive axi_rvalid from FIFO non-empty, and axi_rdata from the FIFO head.
REQ-024 SHALL pop the FIFO on axi_rvalid&&axi_rready.
REQ-025 SHALL hold axi_rdata and axi_rlast stable while axi_rvalid=1 and axi_rready=0.
REQ-026 SHALL support push and pop in the same cycle, with occupancy unchanged.
REQ-027 SHALL assert axi_rlast=2'b01 with the beat whose index is count-1.
REQ-028 SHALL move RUN->IDLE in the cycle after the last beat is accepted; axi_arready rises then.
REQ-029 SHALL NOT accept an axi_rreq that coincides with the last-beat handshake; it is accepted at the earliest in the next IDLE cycle.
REQ-030 SHALL give minimum latency of acceptance at edge T, ram_en high during cycle T+1, and first axi_rvalid in cycle T+2.
REQ-031 SHALL sustain 1 beat/cycle when axi_rready=1 constantly, so an 8-beat burst completes with its last beat at T+9.
REQ-032 SHALL ignore axi_raddr/axi_rtype changes after acceptance.
REQ-033 SHALL keep the beat and issue counters at 4 bits, with no overflow for BURST_LEN<=8.

Reset
REQ-034 SHALL, on rst assertion, immediately force state=IDLE, clear the FIFO and counters, and drop in-flight RAM data.
REQ-035 SHALL hold these output values during reset: axi_arready=0, axi_rvalid=0, axi_rlast=2'b00, axi_rdata=0, ram_en=0, ram_addr=0.
REQ-036 SHALL drive axi_arready=1 in the first cycle after rst deasserts.
REQ-037 SHALL, on reset mid-burst, lose the remaining beats and issue no further ram_en.

Verification
REQ-038 Single read: rtype=2'b10, raddr=0x1FC0_0004, RAM word=0x2410_0001, rready=1 -> ram_addr=0x1FC0_0004, exactly one beat 0x2410_0001 with rlast=2'b01 at T+2, arready=1 at T+3.
REQ-039 Line burst: rtype=2'b11, raddr=0x0000_1014 -> ram_addr 0x1000,0x1004,..,0x101C; 8 consecutive beats; rlast=2'b01 only on the 8th beat, at T+9.
REQ-040 Backpressure: burst with rready toggled 1,0,0,1,... -> no beat lost or duplicated, data held while stalled, at most 2 reads outstanding, ram_en low while the FIFO plus in-flight reads total 2.
REQ-041 Back-to-back: second rreq held high during the first burst's last beat -> second request is accepted only one cycle after the last handshake; addresses and data are not mixed between the two transactions.
REQ-042 Reset mid-burst: rst pulsed after beat 3 of 8 -> rvalid=0 and ram_en=0 immediately; after release, arready=1 and a fresh single read returns correct data.
